// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the programmable clock divider.
//   DIV_MIN   : smallest legal division ratio.
//   sat_div   : clamps a requested ratio up to DIV_MIN (0 and 1 become 2).
//   half_ceil : length of the high phase, H = ceil(N/2).
package clkdiv_pkg;

  localparam int unsigned DIV_MIN = 2;

  function automatic int unsigned sat_div(input int unsigned v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

  // Shift-and-add form keeps this overflow-free at the maximum ratio.
  function automatic int unsigned half_ceil(input int unsigned n);
    return (n >> 1) + (n & 32'd1);
  endfunction

endpackage

// File: rtl/clkdiv_prog.sv
// clkdiv_prog: programmable, glitch-free integer clock divider.
//
// Divides clk_in by a runtime-loadable ratio N (2 .. 2^WIDTH-1). A new ratio
// is captured into a pending slot and only takes effect at a period boundary,
// so clk_out never produces a runt pulse. Rise/fall strobes are provided in
// the clk_in domain for logic that must not clock off clk_out.
//
// Optional feature macro: CLKDIV_GATE_EN adds the `en` run/stop input, which
// is sampled only at period boundaries.
//
// Parameters:
//   WIDTH     : width of the ratio and of the period counter.
//   DIV_RESET : ratio active out of reset (>= 2).
// Ports:
//   clk_in    : source clock, all logic on its rising edge.
//   rst       : synchronous active-high reset.
//   en        : (CLKDIV_GATE_EN only) run/stop request.
//   div_val   : requested ratio; 0 and 1 saturate to 2.
//   div_load  : one-cycle request to capture div_val.
//   div_busy  : a captured ratio is pending; further loads are ignored.
//   clk_out   : registered divided clock.
//   tick_rise : one-cycle pulse in the cycle clk_out goes 0->1.
//   tick_fall : one-cycle pulse in the cycle clk_out goes 1->0.
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV_RESET = 2
) (
  input  logic             clk_in,
  input  logic             rst,
`ifdef CLKDIV_GATE_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_busy,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // cnt holds the phase index k that the next edge will present on the
  // registered outputs; k = 0 at that edge marks a period boundary.
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] n_act;
  logic [WIDTH-1:0] n_pend;
  logic             pend;

  logic             run;
  logic             boundary;
  logic             apply;
  logic             last;
  logic [WIDTH-1:0] n_use;
  logic [WIDTH-1:0] h_use;

`ifdef CLKDIV_GATE_EN
  assign run = en;
`else
  assign run = 1'b1;
`endif

  always_comb begin
    boundary = (cnt == '0);
    // A pending ratio switches in only at a running boundary; the period
    // starting at this edge already uses the new ratio and its H.
    apply    = boundary && pend && run;
    n_use    = apply ? n_pend : n_act;
    h_use    = WIDTH'(half_ceil(32'(n_use)));
    last     = (cnt == (n_use - ONE));
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt       <= '0;
      n_act     <= WIDTH'(DIV_RESET);
      n_pend    <= WIDTH'(DIV_RESET);
      pend      <= 1'b0;
      clk_out   <= 1'b0;
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
    end else begin
      if (boundary && !run) begin
        // Stopped: park at k = 0 after a complete low phase.
        clk_out   <= 1'b0;
        tick_rise <= 1'b0;
        tick_fall <= 1'b0;
      end else begin
        clk_out   <= (cnt < h_use);
        tick_rise <= boundary;
        tick_fall <= (cnt == h_use);
        cnt       <= last ? '0 : cnt + ONE;
      end

      // Pend is still 0 in a capture cycle, so a load on a boundary can
      // never apply at that same boundary.
      if (apply) begin
        n_act <= n_pend;
        pend  <= 1'b0;
      end else if (div_load && !pend) begin
        n_pend <= WIDTH'(sat_div(32'(div_val)));
        pend   <= 1'b1;
      end
    end
  end

  assign div_busy = pend;

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: directed self-checking bench for clkdiv_prog.
// Each cycle compares the packed observation {clk_out, tick_rise, tick_fall,
// div_busy} against hand-computed vectors.
module tb_clkdiv_prog;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] div_val = '0;
  logic       div_load = 1'b0;
  logic       div_busy;
  logic       clk_out;
  logic       tick_rise;
  logic       tick_fall;
`ifdef CLKDIV_GATE_EN
  logic       en = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  clkdiv_prog #(.WIDTH(8), .DIV_RESET(2)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
`ifdef CLKDIV_GATE_EN
    .en        (en),
`endif
    .div_val   (div_val),
    .div_load  (div_load),
    .div_busy  (div_busy),
    .clk_out   (clk_out),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall)
  );

  always #5 clk_in = ~clk_in;

  // Advance past one rising edge; outputs are stable when this returns.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    logic [3:0] exp_v;
    rst = 1'b1;
    cyc();
    cyc();
    obs = {clk_out, tick_rise, tick_fall, div_busy};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got %b expected 0000", obs);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      exp_v = (i % 2 == 0) ? 4'b1100 : 4'b0010;
      obs = {clk_out, tick_rise, tick_fall, div_busy};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_n2_cycle%0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  // Switch to N=4, then load 5 mid-period: high 3 / low 2 afterwards.
  task automatic test_load_mid();
    logic [3:0] obs;
    logic       ld [16] = '{1,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0};
    logic [7:0] vl [16] = '{4,0,0,5,0,0,0,0,0,0,0,0,0,0,0,0};
    logic [3:0] ex [16] = '{4'b1101, 4'b0011, 4'b1100, 4'b1001,
                            4'b0011, 4'b0001, 4'b1100, 4'b1000,
                            4'b1000, 4'b0010, 4'b0000, 4'b1100,
                            4'b1000, 4'b1000, 4'b0010, 4'b0000};
    for (int i = 0; i < 16; i++) begin
      div_load = ld[i];
      div_val  = vl[i];
      cyc();
      div_load = 1'b0;
      obs = {clk_out, tick_rise, tick_fall, div_busy};
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL load_mid_cycle%0d: got %b expected %b", i, obs, ex[i]);
      end
    end
  endtask

  // Loads of 0 and 1 saturate to 2; loads of 7 while busy are dropped.
  task automatic test_saturate();
    logic [3:0] obs;
    logic       ld [13] = '{1,0,1,0,0,0,0,1,1,0,0,0,0};
    logic [7:0] vl [13] = '{0,0,7,0,0,0,0,1,7,0,0,0,0};
    logic [3:0] ex [13] = '{4'b1101, 4'b1001, 4'b1001, 4'b0011,
                            4'b0001, 4'b1100, 4'b0010, 4'b1101,
                            4'b0011, 4'b1100, 4'b0010, 4'b1100,
                            4'b0010};
    for (int i = 0; i < 13; i++) begin
      div_load = ld[i];
      div_val  = vl[i];
      cyc();
      div_load = 1'b0;
      obs = {clk_out, tick_rise, tick_fall, div_busy};
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL saturate_cycle%0d: got %b expected %b", i, obs, ex[i]);
      end
    end
  endtask

  // Reach N=3, then load 6 exactly on a boundary: one more N=3 period first.
  task automatic test_boundary_load();
    logic [3:0] obs;
    logic       ld [9] = '{1,0,0,0,0,1,0,0,0};
    logic [7:0] vl [9] = '{3,0,0,0,0,6,0,0,0};
    logic [3:0] ex [9] = '{4'b1101, 4'b0011, 4'b1100, 4'b1000, 4'b0010,
                           4'b1101, 4'b1001, 4'b0011, 4'b1100};
    for (int i = 0; i < 9; i++) begin
      div_load = ld[i];
      div_val  = vl[i];
      cyc();
      div_load = 1'b0;
      obs = {clk_out, tick_rise, tick_fall, div_busy};
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL boundary_load_cycle%0d: got %b expected %b", i, obs, ex[i]);
      end
    end
  endtask

  // N=6 running at k=0; load 4 at k=1, reset after k=2. Pending load is
  // discarded and the divider restarts at N=2.
  task automatic test_reset_mid();
    logic [3:0] obs;
    logic       ld [6] = '{1,0,0,0,0,0};
    logic       rs [6] = '{0,0,1,0,0,0};
    logic [3:0] ex [6] = '{4'b1001, 4'b1001, 4'b0000,
                           4'b1100, 4'b0010, 4'b1100};
    for (int i = 0; i < 6; i++) begin
      div_load = ld[i];
      div_val  = 8'd4;
      rst      = rs[i];
      cyc();
      div_load = 1'b0;
      rst      = 1'b0;
      obs = {clk_out, tick_rise, tick_fall, div_busy};
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL reset_mid_cycle%0d: got %b expected %b", i, obs, ex[i]);
      end
    end
  endtask

  // Maximum ratio 255: high for k=0..127, fall at k=128, wrap after k=254.
  task automatic test_max_ratio();
    logic [3:0] obs;
    logic [3:0] exp_v;
    int         bad;
    rst = 1'b1;
    cyc();
    rst      = 1'b0;
    div_load = 1'b1;
    div_val  = 8'd255;
    cyc();
    div_load = 1'b0;
    obs = {clk_out, tick_rise, tick_fall, div_busy};
    checks++;
    if (obs !== 4'b1101) begin
      errors++;
      $display("FAIL max_capture: got %b expected 1101", obs);
    end
    cyc();
    cyc();
    obs = {clk_out, tick_rise, tick_fall, div_busy};
    checks++;
    if (obs !== 4'b1100) begin
      errors++;
      $display("FAIL max_apply: got %b expected 1100", obs);
    end
    bad = 0;
    for (int k = 1; k < 255; k++) begin
      cyc();
      exp_v = {(k < 128), 1'b0, (k == 128), 1'b0};
      obs = {clk_out, tick_rise, tick_fall, div_busy};
      if (obs !== exp_v && bad == 0) begin
        bad = 1;
        errors++;
        $display("FAIL max_phase_k%0d: got %b expected %b", k, obs, exp_v);
      end
    end
    checks++;
    cyc();
    obs = {clk_out, tick_rise, tick_fall, div_busy};
    checks++;
    if (obs !== 4'b1100) begin
      errors++;
      $display("FAIL max_wrap: got %b expected 1100", obs);
    end
  endtask

`ifdef CLKDIV_GATE_EN
  // N=4, drop en at k=1; period completes, output parks low. A ratio loaded
  // while stopped applies on the restart boundary.
  task automatic test_gate();
    logic [3:0] obs;
    logic       ev [11] = '{1,1,1,1,0,0,0,0,0,1,1};
    logic       ld [11] = '{1,0,0,0,0,0,0,1,0,0,0};
    logic [7:0] vl [11] = '{4,0,0,0,0,0,0,2,0,0,0};
    logic [3:0] ex [11] = '{4'b1101, 4'b0011, 4'b1100, 4'b1000,
                            4'b0010, 4'b0000, 4'b0000, 4'b0001,
                            4'b0001, 4'b1100, 4'b0010};
    rst = 1'b1;
    en  = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      en       = ev[i];
      div_load = ld[i];
      div_val  = vl[i];
      cyc();
      div_load = 1'b0;
      obs = {clk_out, tick_rise, tick_fall, div_busy};
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL gate_cycle%0d: got %b expected %b", i, obs, ex[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_mid();
    test_saturate();
    test_boundary_load();
    test_reset_mid();
    test_max_ratio();
`ifdef CLKDIV_GATE_EN
    test_gate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
